// File: rtl/breadboard_sweep_ctrl.sv
// Self-test sequencer for the f6..f9 breadboard stage: sweeps all 16 input codes,
// captures r6..r9 for each code and scores the captures against golden truth tables.
module breadboard_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [15:0] GOLD_F6       = 16'h212E,
    parameter logic [15:0] GOLD_F7       = 16'h1668,
    parameter logic [15:0] GOLD_F8       = 16'h8888,
    parameter logic [15:0] GOLD_F9       = 16'h6996
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       w,
    output logic       x,
    output logic       y,
    output logic       z,
    input  logic       r6,
    input  logic       r7,
    input  logic       r8,
    input  logic       r9,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic       first_err_valid,
    output logic [3:0] first_err_idx,
    input  logic [3:0] rd_idx,
    output logic [3:0] rd_data
);

    // A zero settle window would sample in the same cycle the code changes.
    localparam int unsigned SettleEff = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
    localparam int unsigned SettleW   = (SettleEff > 1) ? $clog2(SettleEff) : 1;
    localparam logic [SettleW-1:0] SettleLast = SettleW'(SettleEff - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StSample,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [4:0]         code_q, code_d;
    logic [SettleW-1:0] settle_q, settle_d;
    logic [4:0]         err_count_q, err_count_d;
    logic               first_err_valid_q, first_err_valid_d;
    logic [3:0]         first_err_idx_q, first_err_idx_d;
    logic               pass_q, pass_d;
    logic [3:0]         cap_table_q [16];
    logic               cap_we;

    logic [3:0] sample;
    logic [3:0] golden;
    logic       mismatch;

    assign sample   = {r6, r7, r8, r9};
    assign golden   = {GOLD_F6[code_q[3:0]], GOLD_F7[code_q[3:0]],
                       GOLD_F8[code_q[3:0]], GOLD_F9[code_q[3:0]]};
    assign mismatch = (sample != golden);

    always_comb begin
        state_d           = state_q;
        code_d            = code_q;
        settle_d          = settle_q;
        err_count_d       = err_count_q;
        first_err_valid_d = first_err_valid_q;
        first_err_idx_d   = first_err_idx_q;
        pass_d            = pass_q;
        cap_we            = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    err_count_d       = 5'd0;
                    first_err_valid_d = 1'b0;
                    first_err_idx_d   = 4'd0;
                    pass_d            = 1'b0;
                    code_d            = 5'd0;
                    settle_d          = '0;
                    state_d           = StDrive;
                end
            end
            StDrive: begin
                settle_d = settle_q + 1'b1;
                if (settle_q == SettleLast) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                cap_we = 1'b1;
                if (mismatch) begin
                    err_count_d = err_count_q + 5'd1;
                    if (!first_err_valid_q) begin
                        first_err_valid_d = 1'b1;
                        first_err_idx_d   = code_q[3:0];
                    end
                end
                if (code_q == 5'd15) begin
                    state_d = StDone;
                end else begin
                    code_d   = code_q + 5'd1;
                    settle_d = '0;
                    state_d  = StDrive;
                end
            end
            StDone: begin
                pass_d  = (err_count_q == 5'd0);
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= StIdle;
            code_q            <= 5'd0;
            settle_q          <= '0;
            err_count_q       <= 5'd0;
            first_err_valid_q <= 1'b0;
            first_err_idx_q   <= 4'd0;
            pass_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            code_q            <= code_d;
            settle_q          <= settle_d;
            err_count_q       <= err_count_d;
            first_err_valid_q <= first_err_valid_d;
            first_err_idx_q   <= first_err_idx_d;
            pass_q            <= pass_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                cap_table_q[i] <= 4'd0;
            end
        end else if (cap_we) begin
            cap_table_q[code_q[3:0]] <= sample;
        end
    end

    assign busy            = (state_q == StDrive) || (state_q == StSample);
    assign done            = (state_q == StDone);
    assign {w, x, y, z}    = busy ? code_q[3:0] : 4'd0;
    assign pass            = pass_q;
    assign err_count       = err_count_q;
    assign first_err_valid = first_err_valid_q;
    assign first_err_idx   = first_err_idx_q;
    assign rd_data         = cap_table_q[rd_idx];

endmodule

// File: tb/tb_breadboard_sweep_ctrl.sv
// Scoreboard bench: two sequencers (settle 2 and settle 0) each driving a faultable
// breadboard model; expected sweep results are queued at stimulus time and checked on done.
module tb_breadboard_sweep_ctrl;

    localparam int unsigned NumInst = 2;
    localparam logic [15:0] TbF6 = 16'h212E;
    localparam logic [15:0] TbF7 = 16'h1668;
    localparam logic [15:0] TbF8 = 16'h8888;
    localparam logic [15:0] TbF9 = 16'h6996;

    typedef struct packed {
        logic [4:0]  errs;
        logic        fvalid;
        logic [3:0]  fidx;
        logic        pass;
        logic [63:0] tbl;
    } exp_t;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    int checks         = 0;
    int failures       = 0;
    int insts_finished = 0;

    function automatic logic [3:0] gold_nib(input logic [3:0] c);
        return {TbF6[c], TbF7[c], TbF8[c], TbF9[c]};
    endfunction

    function automatic void chk(input string name, input int inst,
                                input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s inst=%0d actual=%0h required=%0h", name, inst, act, req);
        end
    endfunction

    for (genvar g = 0; g < NumInst; g++) begin : g_inst
        localparam int unsigned Settle   = (g == 0) ? 2 : 0;
        localparam int unsigned Hold     = ((Settle == 0) ? 1 : Settle) + 1;
        localparam int unsigned SweepLen = 16 * Hold;

        logic       rst_n, start;
        logic       w, x, y, z;
        logic       r6, r7, r8, r9;
        logic       busy, done, pass;
        logic [4:0] err_count;
        logic       first_err_valid;
        logic [3:0] first_err_idx, rd_idx, rd_data;
        logic [3:0] fault_mask [16];
        logic [3:0] code;
        exp_t       exp_q [$];
        int         sweeps_seen = 0;

        // Breadboard model: golden function with a per-code XOR fault pattern.
        assign code             = {w, x, y, z};
        assign {r6, r7, r8, r9} = gold_nib(code) ^ fault_mask[code];

        breadboard_sweep_ctrl #(
            .SETTLE_CYCLES(Settle)
        ) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .start          (start),
            .w              (w),
            .x              (x),
            .y              (y),
            .z              (z),
            .r6             (r6),
            .r7             (r7),
            .r8             (r8),
            .r9             (r9),
            .busy           (busy),
            .done           (done),
            .pass           (pass),
            .err_count      (err_count),
            .first_err_valid(first_err_valid),
            .first_err_idx  (first_err_idx),
            .rd_idx         (rd_idx),
            .rd_data        (rd_data)
        );

        task automatic set_mask(input int mode);
            for (int c = 0; c < 16; c++) begin
                case (mode)
                    0:       fault_mask[c] = 4'h0;
                    1:       fault_mask[c] = gold_nib(4'(c)) & 4'b0010;  // r8 stuck at 0
                    2:       fault_mask[c] = 4'b0001;                    // r9 inverted
                    default: fault_mask[c] = ($urandom_range(3) == 0) ?
                                             4'($urandom_range(15, 1)) : 4'h0;
                endcase
            end
        endtask

        task automatic push_exp();
            exp_t e;
            e = '0;
            for (int c = 0; c < 16; c++) begin
                logic [3:0] act;
                act = gold_nib(4'(c)) ^ fault_mask[c];
                e.tbl[c*4 +: 4] = act;
                if (act != gold_nib(4'(c))) begin
                    if (!e.fvalid) begin
                        e.fvalid = 1'b1;
                        e.fidx   = 4'(c);
                    end
                    e.errs = e.errs + 5'd1;
                end
            end
            e.pass = (e.errs == 5'd0);
            exp_q.push_back(e);
        endtask

        task automatic pulse_start();
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        endtask

        task automatic wait_sweeps(input int n);
            int b;
            b = 0;
            while (sweeps_seen < n && b < 2 * SweepLen + 50) begin
                @(negedge clk);
                b++;
            end
            chk("sweep_complete", g, 64'(sweeps_seen >= n), 64'd1);
        endtask

        task automatic wait_code(input logic [3:0] c);
            int b;
            b = 0;
            while (!(busy && code == c) && b < SweepLen + 10) begin
                @(negedge clk);
                b++;
            end
            chk("reach_code", g, 64'(busy && code == c), 64'd1);
        endtask

        task automatic wait_done();
            int b;
            b = 0;
            while (!done && b < SweepLen + 10) begin
                @(negedge clk);
                b++;
            end
            chk("reach_done", g, 64'(done), 64'd1);
        endtask

        task automatic wait_busy();
            int b;
            b = 0;
            while (!busy && b < 10) begin
                @(negedge clk);
                b++;
            end
            chk("restart_busy", g, 64'(busy), 64'd1);
        endtask

        initial begin : stim
            int n;
            rst_n = 1'b0;
            start = 1'b0;
            set_mask(0);
            repeat (3) @(negedge clk);
            chk("rst_busy", g, 64'(busy), 64'd0);
            chk("rst_done", g, 64'(done), 64'd0);
            chk("rst_pass", g, 64'(pass), 64'd0);
            chk("rst_err_count", g, 64'(err_count), 64'd0);
            chk("rst_first_valid", g, 64'(first_err_valid), 64'd0);
            chk("rst_first_idx", g, 64'(first_err_idx), 64'd0);
            chk("rst_code", g, 64'(code), 64'd0);
            chk("rst_rd_data", g, 64'(rd_data), 64'd0);
            rst_n = 1'b1;
            @(negedge clk);

            // Ideal, r8 stuck at 0, r9 inverted.
            for (int m = 0; m < 3; m++) begin
                set_mask(m);
                push_exp();
                pulse_start();
                wait_sweeps(m + 1);
            end
            n = 3;

            // Extra start pulses mid-sweep and in the done cycle are ignored.
            set_mask(0);
            push_exp();
            pulse_start();
            wait_code(4'd5);
            pulse_start();
            wait_done();
            pulse_start();
            repeat (3) @(negedge clk);
            chk("no_restart", g, 64'(busy), 64'd0);
            n++;
            wait_sweeps(n);

            // Async reset mid-sweep: no result survives, next sweep restarts at code 0.
            set_mask(1);
            pulse_start();
            wait_code(4'd7);
            #5 rst_n = 1'b0;
            #1;
            chk("midrst_busy", g, 64'(busy), 64'd0);
            chk("midrst_code", g, 64'(code), 64'd0);
            chk("midrst_err_count", g, 64'(err_count), 64'd0);
            chk("midrst_pass", g, 64'(pass), 64'd0);
            chk("midrst_first_valid", g, 64'(first_err_valid), 64'd0);
            @(negedge clk);
            #5 rst_n = 1'b1;
            @(negedge clk);
            set_mask(2);
            push_exp();
            pulse_start();
            n++;
            wait_sweeps(n);

            // Start held high: back-to-back sweeps.
            set_mask(3);
            push_exp();
            push_exp();
            start = 1'b1;
            wait_sweeps(n + 1);
            wait_busy();
            start = 1'b0;
            n += 2;
            wait_sweeps(n);

            for (int k = 0; k < 4; k++) begin
                set_mask(3);
                push_exp();
                pulse_start();
                n++;
                wait_sweeps(n);
            end
            repeat (4) @(negedge clk);
            chk("queue_drained", g, 64'(exp_q.size()), 64'd0);
            insts_finished++;
        end

        initial begin : mon
            int         cyc;
            logic       busy_prev;
            logic       seq_ok;
            logic [3:0] seen [$];
            exp_t       e;
            cyc       = 0;
            busy_prev = 1'b0;
            rd_idx    = 4'd0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    cyc       = 0;
                    busy_prev = 1'b0;
                    seen.delete();
                end else begin
                    if (busy && !busy_prev) cyc = 1;
                    else if (cyc > 0) cyc++;
                    busy_prev = busy;
                    if (busy) seen.push_back(code);
                    if (done) begin
                        chk("done_cycle", g, 64'(cyc), 64'(SweepLen + 1));
                        seq_ok = (seen.size() == SweepLen);
                        for (int i = 0; i < seen.size(); i++) begin
                            if (seen[i] != 4'(i / Hold)) seq_ok = 1'b0;
                        end
                        chk("code_sequence", g, 64'(seq_ok), 64'd1);
                        chk("done_expected", g, 64'(exp_q.size() != 0), 64'd1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            @(posedge clk);
                            #1;
                            chk("done_one_cycle", g, 64'(done), 64'd0);
                            chk("err_count", g, 64'(err_count), 64'(e.errs));
                            chk("first_err_valid", g, 64'(first_err_valid), 64'(e.fvalid));
                            chk("first_err_idx", g, 64'(first_err_idx), 64'(e.fidx));
                            chk("pass", g, 64'(pass), 64'(e.pass));
                            for (int i = 0; i < 16; i++) begin
                                rd_idx = 4'(i);
                                #1;
                                chk($sformatf("rd_data[%0d]", i), g, 64'(rd_data),
                                    64'(e.tbl[i*4 +: 4]));
                            end
                        end
                        seen.delete();
                        cyc = 0;
                        sweeps_seen++;
                    end
                end
            end
        end
    end

    initial begin : main
        int b;
        b = 0;
        while (insts_finished < NumInst && b < 20000) begin
            @(negedge clk);
            b++;
        end
        chk("all_finished", -1, 64'(insts_finished), 64'(NumInst));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
